// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter: bus request/response
// structs, transfer size encoding and the arbiter state enum.
package mem_arbiter_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } mbus_req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // A fetch returns one 32-bit instruction word out of the 64-bit memory beat.
    function automatic logic [31:0] ibus_lane(input addr_t addr, input word_t data);
        return addr[2] ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the core-side (ibus/dbus) and memory-side signals of the arbiter.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;

    logic    mreq_valid;
    addr_t   mreq_addr;
    msize_t  mreq_size;
    strobe_t mreq_strobe;
    word_t   mreq_data;
    logic    mresp_data_ok;
    word_t   mresp_data;

    modport master (
        output ireq, dreq, mresp_data_ok, mresp_data,
        input  iresp, dresp, mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data
    );

    modport slave (
        input  ireq, dreq, mresp_data_ok, mresp_data,
        output iresp, dresp, mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data
    );

endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Saturating busy-cycle counter with a sticky flag for a memory transaction
// that never completes. TIMEOUT_CYCLES = 0 disables the flag.
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    input  logic done,
    output logic err
);

    localparam bit          ENABLE = (TIMEOUT_CYCLES > 0);
    localparam int unsigned CW     = ENABLE ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT   = CW'(ENABLE ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (!busy) begin
            cnt_d = '0;
        end else if (!done && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (ENABLE && busy && !done && cnt_q == LIMIT) begin
            err_d = 1'b1;
        end
    end

    // NOTE: registers use non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the fetch bus and the data bus: one outstanding
// transaction, fixed priority, registered downstream request, combinational response.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter bit DPRIO          = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic          grant_d,
    output logic          err_timeout
);

    arb_state_t state_q, state_d;
    mbus_req_t  mreq_q, mreq_d;
    logic       grant_d_q, grant_d_d;
    logic       dbus_wins;
    ibus_resp_t iresp_c;
    dbus_resp_t dresp_c;

    assign dbus_wins = bus.dreq.valid && (DPRIO || !bus.ireq.valid);

    always_comb begin
        state_d   = state_q;
        mreq_d    = mreq_q;
        grant_d_d = grant_d_q;
        case (state_q)
            IDLE: begin
                if (dbus_wins) begin
                    state_d   = BUSY_D;
                    grant_d_d = 1'b1;
                    mreq_d    = '{valid:  1'b1,
                                  addr:   bus.dreq.addr,
                                  size:   bus.dreq.size,
                                  strobe: bus.dreq.strobe,
                                  data:   bus.dreq.data};
                end else if (bus.ireq.valid) begin
                    state_d = BUSY_I;
                    mreq_d  = '{valid:  1'b1,
                                addr:   bus.ireq.addr,
                                size:   MSIZE4,
                                strobe: '0,
                                data:   '0};
                end
            end
            BUSY_I, BUSY_D: begin
                // Completion always returns through IDLE, giving one bubble cycle.
                if (bus.mresp_data_ok) begin
                    state_d      = IDLE;
                    mreq_d.valid = 1'b0;
                    grant_d_d    = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mreq_d    = '0;
                grant_d_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mreq_q    <= '0;
            grant_d_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mreq_q    <= mreq_d;
            grant_d_q <= grant_d_d;
        end
    end

    // A requester that dropped valid mid-transaction has its response gated off.
    always_comb begin
        iresp_c = '0;
        dresp_c = '0;
        case (state_q)
            BUSY_I: begin
                iresp_c.data_ok = bus.mresp_data_ok && bus.ireq.valid;
                iresp_c.addr_ok = bus.mresp_data_ok && bus.ireq.valid;
                iresp_c.data    = ibus_lane(mreq_q.addr, bus.mresp_data);
            end
            BUSY_D: begin
                dresp_c.data_ok = bus.mresp_data_ok && bus.dreq.valid;
                dresp_c.addr_ok = bus.mresp_data_ok && bus.dreq.valid;
                dresp_c.data    = bus.mresp_data;
            end
            default: ;
        endcase
    end

    assign bus.iresp       = iresp_c;
    assign bus.dresp       = dresp_c;
    assign bus.mreq_valid  = mreq_q.valid;
    assign bus.mreq_addr   = mreq_q.addr;
    assign bus.mreq_size   = mreq_q.size;
    assign bus.mreq_strobe = mreq_q.strobe;
    assign bus.mreq_data   = mreq_q.data;
    assign grant_d         = grant_d_q;

    arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .busy  (state_q != IDLE),
        .done  (bus.mresp_data_ok),
        .err   (err_timeout)
    );

endmodule
